// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the 1024x8 single-port RAM (IDLE -> XFER -> RESP).
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module ram_arbiter_rport #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= i_load;
      if (i_load) o_rdata <= i_data;
    end
  end
endmodule

module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata0,
  output logic [DW-1:0] o_rdata1,
  output logic          o_ram_en,
  output logic [AW-1:0] o_ram_address,
  output logic [DW-1:0] o_ram_datain,
  input  logic [DW-1:0] i_ram_dataout,
  output logic          o_busy
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_we, r_id;
  logic [AW-1:0]         r_addr;
  logic [DW-1:0]         r_wdata;
  logic                  w_win, w_xfer;
  logic [1:0]            w_req, w_we, w_load, w_rvalid;
  logic [1:0][AW-1:0]    w_addr;
  logic [1:0][DW-1:0]    w_wdata, w_rdata;

  assign w_req   = {i_req1, i_req0};
  assign w_we    = {i_we1, i_we0};
  assign w_addr  = {i_addr1, i_addr0};
  assign w_wdata = {i_wdata1, i_wdata0};

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_win = ~i_req0;
`else
  logic r_last;
  // On contention the requester not granted last wins; otherwise the sole requester.
  assign w_win = (i_req0 & i_req1) ? ~r_last : i_req1;

  always_ff @(posedge i_clk) begin
    if (i_rst)                 r_last <= 1'b1;
    else if (r_state == XFER)  r_last <= r_id;
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_next = XFER;
      XFER:    w_next = r_we ? IDLE : RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |w_req) begin
        r_we    <= w_we[w_win];
        r_id    <= w_win;
        r_addr  <= w_addr[w_win];
        r_wdata <= w_wdata[w_win];
      end
    end
  end

  // Reset gates the XFER strobes combinationally so an in-flight write never reaches the RAM.
  assign w_xfer        = (r_state == XFER) && !i_rst;
  assign o_ram_en      = w_xfer & r_we;
  assign o_gnt0        = w_xfer & ~r_id;
  assign o_gnt1        = w_xfer & r_id;
  assign o_ram_address = r_addr;
  assign o_ram_datain  = r_wdata;
  assign o_busy        = (r_state != IDLE);

  for (genvar g = 0; g < 2; g++) begin : g_rport
    assign w_load[g] = (r_state == RESP) && (r_id == 1'(g));
    ram_arbiter_rport #(.DW(DW)) u_rport (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_load[g]),
      .i_data   (i_ram_dataout),
      .o_rvalid (w_rvalid[g]),
      .o_rdata  (w_rdata[g])
    );
  end

  assign o_rvalid0 = w_rvalid[0];
  assign o_rvalid1 = w_rvalid[1];
  assign o_rdata0  = w_rdata[0];
  assign o_rdata1  = w_rdata[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 1024x8 RAM model.
module tb_ram_arbiter;
  typedef struct packed {
    logic       we;
    logic [9:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2];
  logic       we  [2];
  logic [9:0] addr [2];
  logic [7:0] wd  [2];
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_en, busy;
  logic [7:0] rdata0, rdata1, ram_datain, ram_dataout;
  logic [9:0] ram_address;
  logic [7:0] mem [1024];

  ent_t       gq0[$], gq1[$];
  logic [7:0] rq0[$], rq1[$];
  int         glog[$];
  int         checks = 0, errors = 0;
  ent_t       me;
  logic [7:0] mr;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(10), .DW(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wd[0]), .i_wdata1(wd[1]),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_ram_en(ram_en),
    .o_ram_address(ram_address), .o_ram_datain(ram_datain),
    .i_ram_dataout(ram_dataout), .o_busy(busy)
  );

  // RAM model: en=1 writes, dataout registered from the presented address.
  always @(posedge clk) begin
    if (ram_en) mem[ram_address] <= ram_datain;
    ram_dataout <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops per-requester expectations whenever the DUT strobes gnt/rvalid.
  always @(negedge clk) begin
    if (gnt0 && gnt1) chk("gnt_overlap", 1, 0);
    if (rvalid0 && rvalid1) chk("rvalid_overlap", 1, 0);
    if (gnt0) begin
      glog.push_back(0);
      if (gq0.size() == 0) chk("gnt0_unexpected", 1, 0);
      else begin
        me = gq0.pop_front();
        chk("gnt0_en", ram_en, me.we);
        chk("gnt0_addr", ram_address, me.a);
        if (me.we) chk("gnt0_data", ram_datain, me.d);
      end
    end
    if (gnt1) begin
      glog.push_back(1);
      if (gq1.size() == 0) chk("gnt1_unexpected", 1, 0);
      else begin
        me = gq1.pop_front();
        chk("gnt1_en", ram_en, me.we);
        chk("gnt1_addr", ram_address, me.a);
        if (me.we) chk("gnt1_data", ram_datain, me.d);
      end
    end
    if (rvalid0) begin
      if (rq0.size() == 0) chk("rvalid0_unexpected", 1, 0);
      else begin mr = rq0.pop_front(); chk("rdata0", rdata0, mr); end
    end
    if (rvalid1) begin
      if (rq1.size() == 0) chk("rvalid1_unexpected", 1, 0);
      else begin mr = rq1.pop_front(); chk("rdata1", rdata1, mr); end
    end
  end

  task automatic expect_q(input int id, input bit w, input logic [9:0] a,
                          input logic [7:0] d, input logic [7:0] exp);
    ent_t e;
    e = '{we: w, a: a, d: d};
    if (id == 0) begin gq0.push_back(e); if (!w) rq0.push_back(exp); end
    else         begin gq1.push_back(e); if (!w) rq1.push_back(exp); end
  endtask

  // Issue one request and hold it until its grant (bounded); returns at the grant's negedge.
  task automatic do_req(input int id, input bit w, input logic [9:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    bit got;
    got = 0;
    expect_q(id, w, a, d, exp);
    we[id] = w; addr[id] = a; wd[id] = d; req[id] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) got = 1;
    end
    if (!got) chk($sformatf("gnt%0d_timeout", id), 0, 1);
    req[id] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (gq0.size() + gq1.size() + rq0.size() + rq1.size()) != 0; k++)
      @(negedge clk);
    chk("drain_pending", gq0.size() + gq1.size() + rq0.size() + rq1.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin req[i] = 0; we[i] = 0; addr[i] = 0; wd[i] = 0; end

    #92;
    chk("rst_gnt",    {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_rdata",  {rdata0, rdata1}, 0);
    chk("rst_ram",    {ram_en, ram_address, ram_datain}, 0);
    chk("rst_busy",   busy, 0);
    #8 rst = 1'b0;

    // Write 800/50: grant one cycle after sample, busy gone the cycle after that.
    @(posedge clk); #1;
    do_req(0, 1, 10'd800, 8'd50, 0);
    chk("busy_in_xfer", busy, 1);
    @(negedge clk);
    chk("busy_after_write", busy, 0);
    do_req(1, 1, 10'd950, 8'd60, 0);

    // Read 800 by req0: rvalid on the 4th negedge after raising req (N+3).
    @(posedge clk); #1;
    expect_q(0, 0, 10'd800, 8'd0, 8'd50);
    we[0] = 0; addr[0] = 10'd800; req[0] = 1;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(negedge clk);
      if (gnt0) req[0] = 0;
      if (rvalid0) n = k;
    end
    chk("read_latency", n, 4);
    do_req(1, 0, 10'd950, 8'd0, 8'd60);
    drain();

    // Both requesters reading continuously.
    @(posedge clk); #1;
    glog.delete();
    fork
      begin for (int i = 0; i < 4; i++) do_req(0, 0, 10'd800, 8'd0, 8'd50); end
      begin for (int j = 0; j < 4; j++) do_req(1, 0, 10'd950, 8'd0, 8'd60); end
    join
    drain();
    chk("glog_size", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk($sformatf("grant_order%0d", i), glog[i], (i < 4) ? 0 : 1);
`else
      chk($sformatf("grant_order%0d", i), glog[i], i % 2);
`endif

    // Reset during XFER of write 800/99: no enable, no grant, location unchanged.
    @(posedge clk); #1;
    we[0] = 1; addr[0] = 10'd800; wd[0] = 8'd99; req[0] = 1;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rst_xfer_en", ram_en, 0);
    chk("rst_xfer_gnt", gnt0, 0);
    req[0] = 0;
    @(posedge clk); #1;
    rst = 0;
    do_req(0, 0, 10'd800, 8'd0, 8'd50);
    drain();

    // Reset during RESP: no rvalid, rdata cleared.
    @(posedge clk); #1;
    gq0.push_back('{we: 1'b0, a: 10'd950, d: 8'd0});
    we[0] = 0; addr[0] = 10'd950; req[0] = 1;
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin @(negedge clk); if (gnt0) n = 1; end
    chk("resp_rst_gnt", n, 1);
    req[0] = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_resp_rvalid", rvalid0, 0);
    chk("rst_resp_rdata", rdata0, 0);

    // Address change while in XFER: latched address is used for this grant only.
    @(posedge clk); #1;
    expect_q(0, 0, 10'd950, 8'd0, 8'd60);
    we[0] = 0; addr[0] = 10'd950; req[0] = 1;
    @(posedge clk); #1;
    addr[0] = 10'd800;
    @(negedge clk);
    chk("latched_gnt", gnt0, 1);
    req[0] = 0;
    drain();
    @(posedge clk); #1;
    do_req(0, 0, 10'd800, 8'd0, 8'd50);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the 1024x8 single-port `ram` block. Serialises write and read transactions from two independent requesters onto the RAM's `en`/`address`/`datain` port. Returns read data to the requester that issued the read. Sits between the RAM and its clients; it is the only block that drives the RAM's control inputs.

## Interface
- `AW`, 10, address width (RAM depth = 2^AW)
- `DW`, 8, data width
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  transaction request; held high, with `we`/`addr`/`wdata` stable, until matching `gnt`
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  AW  target address
- `wdata0`, `wdata1`  in  DW  write data
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted and driven to RAM this cycle
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdataN` valid
- `rdata0`, `rdata1`  out  DW  read data, held until next read completion for that requester
- `ram_en`  out  1  to RAM `en`: 1 = write, 0 = read
- `ram_address`  out  AW  to RAM `address`
- `ram_datain`  out  DW  to RAM `datain`
- `ram_dataout`  in  DW  from RAM `dataout`; registered, valid the cycle after a read address is presented
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE: if any `reqN` high, select winner, latch its `we`/`addr`/`wdata`/id into internal registers, go to XFER; otherwise stay.
- XFER: drive `ram_en`=latched `we`, `ram_address`/`ram_datain` from latched registers; pulse `gntN` for winner. Write -> IDLE. Read -> RESP.
- RESP: register `ram_dataout` into `rdataN` of latched id, pulse `rvalidN` next cycle; -> IDLE.
- Outside XFER: `ram_en`=0, `ram_address` holds last value, `ram_datain` holds last value. Idle reads are harmless.
- Arbitration, default round-robin: one requester -> it wins. Both -> the one not granted last. `last` pointer updated only on grant; reset value 1, so `req0` wins the first contention.
- Losing requester keeps `req` high and is served in the next IDLE. With both requesters continuously active, grants alternate strictly.
- Request sampled only in IDLE; `req` changes in XFER/RESP are ignored until return to IDLE.

## Timing
- Reset values: `gnt0/1`=0, `rvalid0/1`=0, `rdata0/1`=0, `ram_en`=0, `ram_address`=0, `ram_datain`=0, `busy`=0, state IDLE, `last`=1.
- Write: `req` sampled cycle N -> `gnt` and RAM write in N+1 -> IDLE in N+2. Throughput: 1 write per 2 cycles.
- Read: `req` sampled N -> `gnt`, address on RAM in N+1 -> RESP in N+2 -> `rvalid`/`rdata` in N+3. The next request is also sampled in N+3. Throughput: 1 read per 3 cycles.
- `rvalid` and `gnt` are never high for both requesters in the same cycle.
- Reset asserted in XFER: `ram_en` forced 0 that cycle, no write reaches RAM, no `gnt` pulse.
- Reset asserted in RESP: no `rvalid`, `rdata` cleared.
- `busy` is high from the cycle after acceptance through the last non-IDLE cycle.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined: fixed priority, `req0` always wins contention; `last` pointer not implemented. `req1` can starve under continuous `req0`.
- Undefined (default): round-robin as above.

## Test plan
- Reset 100 ns, then `req0` write `addr0`=800, `wdata0`=50 -> `gnt0` one cycle later with `ram_en`=1, `ram_address`=800, `ram_datain`=50; `busy` drops 2 cycles after sample.
- `req1` write 950/60, then `req0` read 800 and `req1` read 950 -> `rvalid0` with `rdata0`=50 exactly 3 cycles after its sample; `rvalid1` with `rdata1`=60.
- Both requesters read continuously from reset -> grant order 0,1,0,1…; no overlapping `gnt`/`rvalid`; `rdata` routed to the correct requester.
- With `RAM_ARB_FIXED_PRIO_EN`, both requesting continuously -> only `gnt0` pulses; `gnt1` only after `req0` drops.
- Assert `rst` during XFER of write 800/99 -> location 800 still reads 50. Assert `rst` during RESP -> no `rvalid`, `rdata`=0.
- `req0` changes `addr0` in XFER -> latched address used; new value only applied on the next grant.
